// File: rtl/latch_byte_loader.sv
// Serial-to-parallel loader for an 8-bit D-latch bank. Collects WIDTH bits MSB first,
// then drives D and E in a latch-safe sequence: setup cycle, E pulse, hold cycle.
module latch_byte_loader #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned E_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] D,
    output logic             E,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bit_count,
    output logic             overrun
);

    localparam int unsigned CNT_W = (E_CYCLES > 1) ? $clog2(E_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(E_CYCLES - 1);
    localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   sr, sr_next;
    logic [WIDTH-1:0]   d_next;
    logic [3:0]         count_next;
    logic               overrun_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    // Next-state and datapath decode
    always_comb begin
        state_next   = state;
        sr_next      = sr;
        d_next       = D;
        count_next   = bit_count;
        overrun_next = overrun;
        cnt_next     = cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = SHIFT;
                    count_next   = 4'd0;
                    sr_next      = '0;
                    overrun_next = 1'b0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else if (bit_valid) begin
                    sr_next    = {sr[WIDTH-2:0], bit_in};
                    count_next = bit_count + 4'd1;
                    if (bit_count == LAST_BIT) begin
                        state_next = SETUP;
                        d_next     = {sr[WIDTH-2:0], bit_in};
                    end
                end
            end
            SETUP: begin
                state_next = PULSE;
                cnt_next   = '0;
            end
            PULSE: begin
                if (cnt == CNT_LAST) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Strobes arriving during a load sequence are dropped but flagged
        if (bit_valid && (state == SETUP || state == PULSE || state == HOLD)) begin
            overrun_next = 1'b1;
        end
    end

    // State and output registers; E/done/busy are decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            D         <= '0;
            E         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_count <= 4'd0;
            overrun   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            D         <= d_next;
            E         <= (state_next == PULSE);
            busy      <= (state_next != IDLE);
            done      <= (state_next == HOLD);
            bit_count <= count_next;
            overrun   <= overrun_next;
            cnt       <= cnt_next;
        end
    end

endmodule

// File: tb/tb_latch_byte_loader.sv
// Directed self-checking bench for latch_byte_loader; a second instance with
// E_CYCLES=1 shares the stimulus and is checked in its own scenario.
module tb_latch_byte_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       abort;
    logic [7:0] D,  D1;
    logic       E,  E1;
    logic       busy, busy1;
    logic       done, done1;
    logic [3:0] bit_count, bit_count1;
    logic       overrun, overrun1;

    int tests  = 0;
    int failed = 0;

    latch_byte_loader #(.WIDTH(8), .E_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .abort(abort), .D(D), .E(E), .busy(busy),
        .done(done), .bit_count(bit_count), .overrun(overrun)
    );

    latch_byte_loader #(.WIDTH(8), .E_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .abort(abort), .D(D1), .E(E1), .busy(busy1),
        .done(done1), .bit_count(bit_count1), .overrun(overrun1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            bit_in    = v[i];
            bit_valid = 1'b1;
            step();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0;
        step();
        step();
        tests++; if ({D, E, busy, done, bit_count, overrun} !== 16'h0) begin
            failed++; $display("FAIL reset_state: got D=%h E=%b busy=%b done=%b cnt=%0d ovr=%b, want all 0",
                               D, E, busy, done, bit_count, overrun);
        end
        reset = 1'b0;
        step();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_basic_load();
        begin_frame();
        tests++; if (busy !== 1'b1 || bit_count !== 4'd0) begin
            failed++; $display("FAIL basic_start: busy=%b cnt=%0d want 1/0", busy, bit_count);
        end
        shift_byte(8'hA6);
        tests++; if (D !== 8'hA6 || E !== 1'b0 || bit_count !== 4'd8) begin
            failed++; $display("FAIL basic_k: D=%h E=%b cnt=%0d want a6/0/8", D, E, bit_count);
        end
        step();
        tests++; if (E !== 1'b1 || D !== 8'hA6 || bit_count !== 4'd8) begin
            failed++; $display("FAIL basic_k1: E=%b D=%h cnt=%0d want 1/a6/8", E, D, bit_count);
        end
        step();
        tests++; if (E !== 1'b1 || done !== 1'b0) begin
            failed++; $display("FAIL basic_k2: E=%b done=%b want 1/0", E, done);
        end
        step();
        tests++; if (E !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || D !== 8'hA6) begin
            failed++; $display("FAIL basic_k3: E=%b done=%b busy=%b D=%h want 0/1/1/a6", E, done, busy, D);
        end
        step();
        tests++; if (busy !== 1'b0 || done !== 1'b0 || D !== 8'hA6) begin
            failed++; $display("FAIL basic_k4: busy=%b done=%b D=%h want 0/0/a6", busy, done, D);
        end
    endtask

    task automatic test_abort();
        begin_frame();
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            step();
        end
        tests++; if (bit_count !== 4'd3) begin failed++; $display("FAIL abort_cnt3: cnt=%0d want 3", bit_count); end
        abort = 1'b1;
        step();
        abort = 1'b0; bit_valid = 1'b0;
        tests++; if (busy !== 1'b0 || bit_count !== 4'd0 || D !== 8'hA6 || E !== 1'b0) begin
            failed++; $display("FAIL abort_idle: busy=%b cnt=%0d D=%h E=%b want 0/0/a6/0", busy, bit_count, D, E);
        end
        step();
        tests++; if (E !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL abort_quiet: E=%b busy=%b want 0/0", E, busy);
        end
        begin_frame();
        shift_byte(8'h3C);
        tests++; if (D !== 8'h3C || E !== 1'b0) begin failed++; $display("FAIL abort_next_D: D=%h E=%b want 3c/0", D, E); end
        step();
        tests++; if (E !== 1'b1) begin failed++; $display("FAIL abort_next_e1: E=%b want 1", E); end
        step();
        tests++; if (E !== 1'b1) begin failed++; $display("FAIL abort_next_e2: E=%b want 1", E); end
        step();
        tests++; if (E !== 1'b0 || done !== 1'b1) begin
            failed++; $display("FAIL abort_next_done: E=%b done=%b want 0/1", E, done);
        end
        step();
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL abort_next_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_overrun();
        begin_frame();
        shift_byte(8'h55);
        step();
        bit_in = 1'b1; bit_valid = 1'b1;
        step();
        bit_valid = 1'b0;
        tests++; if (overrun !== 1'b1 || E !== 1'b1 || D !== 8'h55) begin
            failed++; $display("FAIL ovr_pulse: ovr=%b E=%b D=%h want 1/1/55", overrun, E, D);
        end
        step();
        tests++; if (E !== 1'b0 || done !== 1'b1 || D !== 8'h55) begin
            failed++; $display("FAIL ovr_hold: E=%b done=%b D=%h want 0/1/55", E, done, D);
        end
        step();
        tests++; if (busy !== 1'b0 || overrun !== 1'b1) begin
            failed++; $display("FAIL ovr_idle: busy=%b ovr=%b want 0/1", busy, overrun);
        end
        begin_frame();
        tests++; if (overrun !== 1'b0 || busy !== 1'b1) begin
            failed++; $display("FAIL ovr_clear: ovr=%b busy=%b want 0/1", overrun, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        begin_frame();
        shift_byte(8'h81);
        step();
        tests++; if (E !== 1'b1) begin failed++; $display("FAIL rst_pre: E=%b want 1", E); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (E !== 1'b0 || D !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            failed++; $display("FAIL rst_async: E=%b D=%h busy=%b done=%b want 0/00/0/0", E, D, busy, done);
        end
        step();
        reset = 1'b0;
        step();
        step();
        step();
        tests++; if (busy !== 1'b0 || E !== 1'b0 || bit_count !== 4'd0) begin
            failed++; $display("FAIL rst_after: busy=%b E=%b cnt=%0d want 0/0/0", busy, E, bit_count);
        end
    endtask

    task automatic test_gaps_and_starts();
        int gap;
        begin_frame();
        for (int i = 0; i < 8; i++) begin
            gap = int'($urandom_range(0, 5));
            bit_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                start = (i == 4);
                step();
            end
            start = (i == 2);
            bit_in = 1'b1; bit_valid = 1'b1;
            step();
        end
        bit_valid = 1'b0; start = 1'b0;
        tests++; if (D !== 8'hFF || bit_count !== 4'd8) begin
            failed++; $display("FAIL gaps_D: D=%h cnt=%0d want ff/8", D, bit_count);
        end
        step();
        step();
        step();
        tests++; if (done !== 1'b1) begin failed++; $display("FAIL gaps_done: done=%b want 1", done); end
        start = 1'b1;
        step();
        start = 1'b0;
        tests++; if (busy !== 1'b0 || D !== 8'hFF) begin
            failed++; $display("FAIL gaps_hold_start: busy=%b D=%h want 0/ff", busy, D);
        end
    endtask

    task automatic test_e_cycles1();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        begin_frame();
        shift_byte(8'hC3);
        tests++; if (D1 !== 8'hC3 || E1 !== 1'b0) begin failed++; $display("FAIL e1_D: D=%h E=%b want c3/0", D1, E1); end
        step();
        tests++; if (E1 !== 1'b1 || done1 !== 1'b0) begin
            failed++; $display("FAIL e1_pulse: E=%b done=%b want 1/0", E1, done1);
        end
        step();
        tests++; if (E1 !== 1'b0 || done1 !== 1'b1) begin
            failed++; $display("FAIL e1_done: E=%b done=%b want 0/1", E1, done1);
        end
        step();
        tests++; if (done1 !== 1'b0 || busy1 !== 1'b0 || D1 !== 8'hC3) begin
            failed++; $display("FAIL e1_idle: done=%b busy=%b D=%h want 0/0/c3", done1, busy1, D1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_abort();
        test_overrun();
        test_reset_mid_pulse();
        test_gaps_and_starts();
        test_e_cycles1();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
